// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data memory.
// One transaction is in flight at a time, and each response goes back to the requester that issued it.
// Data has priority, but a starvation counter makes sure fetch still gets through.
// A fetch can be killed, which discards its response.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W       = DATA_W / 8;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_dm;   // 1: the data stage owns the in-flight access
  logic                r_kill;
  logic [3:0]          r_starve_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_be;
  logic                w_dm_win;
  logic                w_if_win;
  logic                w_accept;
  logic                w_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration, next state, and the gnt/rvalid strobes (combinational on mem_ready/mem_rvalid)
  always_comb begin
    w_state_nxt = r_state;
    w_dm_win    = 1'b0;
    w_if_win    = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    dm_rvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dm_win = dm_req && (!if_req || (r_starve_cnt < STARVE_MAX));
        w_if_win = if_req && !w_dm_win;
        if (w_dm_win || w_if_win) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_accept    = 1'b1;
          if_gnt      = !r_owner_dm;
          dm_gnt      = r_owner_dm;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_done      = 1'b1;
          dm_rvalid   = r_owner_dm;
          // A kill arriving alongside the response still discards it
          if_rvalid   = !r_owner_dm && !r_kill && !if_kill;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the winner's access into the memory port and hold it until it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_owner_dm  <= 1'b0;
    end else if (w_dm_win) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= dm_we;
      r_mem_addr  <= dm_addr;
      r_mem_wdata <= dm_wdata;
      r_mem_be    <= dm_be;
      r_owner_dm  <= 1'b1;
    end else if (w_if_win) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= '1;
      r_owner_dm  <= 1'b0;
    end else if (w_accept) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Kill flag: remembers that the in-flight fetch response must be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kill <= 1'b0;
    end else if (w_done) begin
      r_kill <= 1'b0;
    end else if (if_kill && !r_owner_dm && (r_state != S_IDLE)) begin
      r_kill <= 1'b1;
    end
  end

  // Starvation counter: consecutive data wins while a fetch is waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (!if_req || w_if_win) begin
        r_starve_cnt <= 4'd0;
      end else if (w_dm_win && (r_starve_cnt < STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench with a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_kill = 1'b0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [BE_W-1:0]   dm_be = '0;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // memory responder knobs and state
  int unsigned       rdy_dly = 0, rv_dly = 2, rdy_cnt = 0, rsp_cnt = 0;
  bit                rsp_pend = 0, spur_en = 0, inject_rv = 0, fix_en = 0, kill_next = 0;
  logic [DATA_W-1:0] fix_data = '0, rsp_data = '0, dlv_data = '0;

  // requester knobs
  bit if_auto = 0, dm_auto = 0, rnd_mode = 0;

  // reference model: one open transaction, its owner, its expected port contents
  bit                txn_open = 0, txn_acc = 0, txn_dm = 0, txn_killed = 0;
  int unsigned       m_starve = 0;
  logic              exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic [BE_W-1:0]   exp_be = '0;
  bit                e_ig = 0, e_dg = 0, e_ir = 0, e_dr = 0, e_done = 0;

  // observed event counters
  int unsigned n_if_gnt_o = 0, n_dm_gnt_o = 0, n_if_rv_o = 0, n_dm_rv_o = 0, n_mreq_o = 0, n_gnt_o = 0;
  logic [9:0]  gnt_bits = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_dm();
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = 32'($urandom()) & 32'hFFFF_FFFC;
    dm_wdata = 32'($urandom());
    dm_be    = 4'($urandom_range(1, 15));
  endtask

  // One clock cycle: model decision for the coming edge, memory response, checks, requester reactions
  task automatic cycle();
    if (rst) begin
      txn_open = 0; txn_acc = 0; txn_killed = 0; m_starve = 0;
    end else begin
      if (e_ig || e_dg) txn_acc = 1;
      if (e_done) begin
        txn_open = 0; txn_killed = 0;
      end else if (!txn_open) begin
        if (dm_req && (!if_req || m_starve < LIMIT)) begin
          txn_open = 1; txn_acc = 0; txn_dm = 1;
          exp_we = dm_we; exp_addr = dm_addr; exp_wdata = dm_wdata; exp_be = dm_be;
          m_starve = if_req ? m_starve + 1 : 0;
        end else if (if_req) begin
          txn_open = 1; txn_acc = 0; txn_dm = 0;
          exp_we = 1'b0; exp_addr = if_addr; exp_be = '1;
          m_starve = 0;
        end else begin
          m_starve = 0;
        end
      end
    end

    @(negedge clk);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'($urandom());
    if_kill    = kill_next;
    kill_next  = 0;
    if (rst) begin
      rsp_pend = 0; rdy_cnt = 0;
    end else begin
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rsp_data; dlv_data = rsp_data; rsp_pend = 0;
        end else begin
          rsp_cnt--;
        end
      end else if (inject_rv || (spur_en && $urandom_range(0, 3) == 0)) begin
        mem_rvalid = 1'b1;
      end
      inject_rv = 0;
      if (mem_req) begin
        if (rdy_cnt >= rdy_dly) begin
          mem_ready = 1'b1; rsp_pend = 1; rsp_cnt = rv_dly - 1; rdy_cnt = 0;
          rsp_data  = fix_en ? fix_data : 32'($urandom());
          if (rnd_mode) begin
            rdy_dly = $urandom_range(0, 3); rv_dly = $urandom_range(1, 3);
          end
        end else begin
          rdy_cnt++;
        end
      end
    end
    #1;

    chk("mem_req", 64'(mem_req), 64'(txn_open && !txn_acc));
    if (txn_open && !txn_acc) begin
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("mem_we", 64'(mem_we), 64'(exp_we));
      chk("mem_be", 64'(mem_be), 64'(exp_be));
      if (exp_we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    if (if_kill && txn_open && !txn_dm) txn_killed = 1;
    e_ig   = txn_open && !txn_acc && !txn_dm && mem_ready;
    e_dg   = txn_open && !txn_acc && txn_dm && mem_ready;
    e_done = txn_open && txn_acc && mem_rvalid;
    e_ir   = e_done && !txn_dm && !txn_killed;
    e_dr   = e_done && txn_dm;
    chk("if_gnt", 64'(if_gnt), 64'(e_ig));
    chk("dm_gnt", 64'(dm_gnt), 64'(e_dg));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_ir));
    chk("dm_rvalid", 64'(dm_rvalid), 64'(e_dr));
    if (e_ir) chk("if_rdata", 64'(if_rdata), 64'(dlv_data));
    if (e_dr && !exp_we) chk("dm_rdata", 64'(dm_rdata), 64'(dlv_data));
    chk("starve_cnt", 64'(dut.r_starve_cnt), 64'(m_starve));

    n_if_gnt_o += 32'(if_gnt);
    n_dm_gnt_o += 32'(dm_gnt);
    n_if_rv_o  += 32'(if_rvalid);
    n_dm_rv_o  += 32'(dm_rvalid);
    n_mreq_o   += 32'(mem_req);
    if (if_gnt) begin
      gnt_bits = {gnt_bits[8:0], 1'b0}; n_gnt_o++;
      if (if_auto) if_addr = 32'($urandom()) & 32'hFFFF_FFFC;
      else if_req = 1'b0;
    end
    if (dm_gnt) begin
      gnt_bits = {gnt_bits[8:0], 1'b1}; n_gnt_o++;
      if (dm_auto) new_dm();
      else dm_req = 1'b0;
    end
    if (rnd_mode) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 32'($urandom()) & 32'hFFFF_FFFC;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; new_dm();
      end
      if ($urandom_range(0, 7) == 0) kill_next = 1;
    end
  endtask

  task automatic run_until_idle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      done = !txn_open && !if_req && !dm_req;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  int unsigned b_ig, b_dg, b_ir, b_dr, b_mr;
  bit          hit;

  initial begin
    // reset state
    cycle();
    cycle();
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    cycle();

    // fetch alone, zero-wait ready, response two cycles after acceptance
    rdy_dly = 0; rv_dly = 2; fix_en = 1; fix_data = 32'h0050_0093;
    if_req = 1'b1; if_addr = 32'h100;
    cycle();
    chk("fetch_mem_req", 64'(mem_req), 64'd1);
    chk("fetch_gnt", 64'(if_gnt), 64'd1);
    chk("fetch_addr", 64'(mem_addr), 64'h100);
    chk("fetch_be", 64'(mem_be), 64'hF);
    chk("fetch_we", 64'(mem_we), 64'd0);
    cycle();
    chk("fetch_rv_early", 64'(if_rvalid), 64'd0);
    cycle();
    chk("fetch_rvalid", 64'(if_rvalid), 64'd1);
    chk("fetch_rdata", 64'(if_rdata), 64'h0050_0093);
    fix_en = 0;
    run_until_idle("fetch_idle");

    // store alone with a 3-cycle ready stall
    b_ig = n_if_gnt_o; b_dg = n_dm_gnt_o; b_ir = n_if_rv_o; b_dr = n_dm_rv_o; b_mr = n_mreq_o;
    rdy_dly = 3; rv_dly = 1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    run_until_idle("store_idle");
    chk("store_mreq_cycles", 64'(n_mreq_o - b_mr), 64'd4);
    chk("store_gnt_count", 64'(n_dm_gnt_o - b_dg), 64'd1);
    chk("store_rv_count", 64'(n_dm_rv_o - b_dr), 64'd1);
    chk("store_if_gnt", 64'(n_if_gnt_o - b_ig), 64'd0);
    chk("store_if_rv", 64'(n_if_rv_o - b_ir), 64'd0);

    // contention: both requesters always busy
    rdy_dly = 0; rv_dly = 1;
    n_gnt_o = 0; gnt_bits = '0;
    if_auto = 1; dm_auto = 1;
    if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b1; new_dm();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      hit = (n_gnt_o >= 10);
    end
    chk("contention_done", 64'(hit), 64'd1);
    chk("grant_order", 64'(gnt_bits), 64'(10'b11110_11110));
    if_auto = 0; dm_auto = 0;
    run_until_idle("contention_drain");

    // kill during WAIT, then a normal fetch
    rdy_dly = 0; rv_dly = 3;
    b_ir = n_if_rv_o; b_ig = n_if_gnt_o;
    if_req = 1'b1; if_addr = 32'h40;
    cycle();
    cycle();
    kill_next = 1;
    run_until_idle("kill_idle");
    chk("kill_gnt", 64'(n_if_gnt_o - b_ig), 64'd1);
    chk("kill_no_rvalid", 64'(n_if_rv_o - b_ir), 64'd0);
    b_ir = n_if_rv_o;
    if_req = 1'b1; if_addr = 32'h80;
    run_until_idle("after_kill_idle");
    chk("after_kill_rvalid", 64'(n_if_rv_o - b_ir), 64'd1);

    // kill in the same cycle as the response
    rv_dly = 2; b_ir = n_if_rv_o;
    if_req = 1'b1; if_addr = 32'h44;
    cycle();
    cycle();
    kill_next = 1;
    run_until_idle("kill_same_idle");
    chk("kill_same_rvalid", 64'(n_if_rv_o - b_ir), 64'd0);

    // kill while data owns the port has no effect on either stream
    b_dr = n_dm_rv_o; b_ir = n_if_rv_o;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_be = 4'hF;
    cycle();
    cycle();
    kill_next = 1;
    run_until_idle("kill_dm_idle");
    if_req = 1'b1; if_addr = 32'h48;
    run_until_idle("kill_dm_fetch_idle");
    chk("kill_dm_rvalid", 64'(n_dm_rv_o - b_dr), 64'd1);
    chk("kill_dm_if_rvalid", 64'(n_if_rv_o - b_ir), 64'd1);

    // asynchronous reset while a request is on the port
    rdy_dly = 5; rv_dly = 2;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_be = 4'hF;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cycle();
      hit = mem_req;
    end
    chk("pre_rst_req", 64'(hit), 64'd1);
    mem_ready = 1'b1;
    #1;
    chk("pre_rst_dm_gnt", 64'(dm_gnt), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_mem_req", 64'(mem_req), 64'd0);
    chk("async_dm_gnt", 64'(dm_gnt), 64'd0);
    chk("async_if_gnt", 64'(if_gnt), 64'd0);
    chk("async_dm_rvalid", 64'(dm_rvalid), 64'd0);
    chk("async_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("async_mem_addr", 64'(mem_addr), 64'd0);
    mem_ready = 1'b0; dm_req = 1'b0;
    txn_open = 0; txn_acc = 0; txn_killed = 0; m_starve = 0;
    e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_done = 0;
    rsp_pend = 0; rdy_cnt = 0; rdy_dly = 0;
    cycle();
    cycle();
    rst = 1'b0;
    b_dr = n_dm_rv_o; b_ir = n_if_rv_o;
    inject_rv = 1;
    cycle();
    cycle();
    chk("late_rv_dm", 64'(n_dm_rv_o - b_dr), 64'd0);
    chk("late_rv_if", 64'(n_if_rv_o - b_ir), 64'd0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'h1234_5678; dm_be = 4'hC;
    run_until_idle("post_rst_idle");
    chk("post_rst_dm_rvalid", 64'(n_dm_rv_o - b_dr), 64'd1);

    // randomized traffic, delays, kills and stray responses
    b_ir = n_if_rv_o; b_dr = n_dm_rv_o;
    rnd_mode = 1; spur_en = 1;
    for (int i = 0; i < 1500; i++) cycle();
    rnd_mode = 0; spur_en = 0; rdy_dly = 0; rv_dly = 1;
    run_until_idle("random_drain");
    chk("random_progress", 64'((n_if_rv_o - b_ir) > 20 && (n_dm_rv_o - b_dr) > 20), 64'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
